// File: rtl/demux8_pkg.sv
// Shared types and constants for the demux8_stream slice.
// The broadcast state is only reachable when DEMUX_BCAST_EN is defined.
package demux8_pkg;

  localparam int SEL_W = 3;
  localparam int N_OUT = 8;

  localparam logic [N_OUT-1:0] ONEHOT_NONE = 8'h00;
  localparam logic [N_OUT-1:0] ONEHOT_ALL  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UNI   = 2'd1,
    BCAST = 2'd2
  } state_e;

  // Observation bundle: FSM state, channels still owed the held word, held select.
  typedef struct packed {
    state_e               state;
    logic [N_OUT-1:0]     pending;
    logic [SEL_W-1:0]     sel;
  } dbg_t;

endpackage

// File: rtl/demux8_stream_dec3to8.sv
// 3-to-8 one-hot decoder with enable; select bit 2 (s0) is the MSB.
// Output is all-zero when disabled.
module dec3to8
  import demux8_pkg::*;
(
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] onehot
);

  always_comb begin
    onehot = ONEHOT_NONE;
    if (en) begin
      case (sel)
        3'b000:  onehot = 8'h01;
        3'b001:  onehot = 8'h02;
        3'b010:  onehot = 8'h04;
        3'b011:  onehot = 8'h08;
        3'b100:  onehot = 8'h10;
        3'b101:  onehot = 8'h20;
        3'b110:  onehot = 8'h40;
        3'b111:  onehot = 8'h80;
        default: onehot = ONEHOT_NONE;
      endcase
    end
  end

endmodule

// File: rtl/demux8_stream.sv
// Registered 1-to-8 stream demultiplexer: one held word on a shared bus, one-hot valid.
// Optional broadcast to all channels is enabled with the DEMUX_BCAST_EN macro.
module demux8_stream
  import demux8_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_sel,
`ifdef DEMUX_BCAST_EN
  input  logic             in_bcast,
`endif
  output logic [WIDTH-1:0] out_data,
  output logic [N_OUT-1:0] out_valid,
  input  logic [N_OUT-1:0] out_ready,
  output dbg_t             dbg
);

  // Handshake rules: a word moves on any port only when valid && ready at the
  // rising clk edge. in_ready is derived from state and out_ready, never from
  // in_valid; out_valid comes from registers only, never from out_ready.

  state_e           state, state_nxt;
  logic [SEL_W-1:0] sel_q, sel_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic [N_OUT-1:0] uni_mask;
  logic             uni_drain;
  logic             ready_raw;
  logic             in_fire;
  logic             bcast_req;
  logic [N_OUT-1:0] pending_view;

`ifdef DEMUX_BCAST_EN
  logic [N_OUT-1:0] pending, pending_nxt;
  logic [N_OUT-1:0] pending_left;

  assign bcast_req    = in_bcast;
  assign pending_left = pending & ~out_ready;
  assign pending_view = pending;
`else
  assign bcast_req    = 1'b0;
  assign pending_view = out_valid;
`endif

  dec3to8 u_dec (
    .en     (state == UNI),
    .sel    (sel_q),
    .onehot (uni_mask)
  );

  assign uni_drain = |(uni_mask & out_ready);

`ifdef DEMUX_BCAST_EN
  assign out_valid = uni_mask | ((state == BCAST) ? pending : ONEHOT_NONE);
`else
  assign out_valid = uni_mask;
`endif

  assign out_data = data_q;

  always_comb begin
    ready_raw = 1'b0;
    case (state)
      IDLE:    ready_raw = 1'b1;
      UNI:     ready_raw = uni_drain;
`ifdef DEMUX_BCAST_EN
      BCAST:   ready_raw = (pending_left == ONEHOT_NONE);
`endif
      default: ready_raw = 1'b0;
    endcase
  end

  // Held low through reset so nothing is accepted on a reset edge.
  assign in_ready = rst_n & ready_raw;
  assign in_fire  = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    data_nxt  = data_q;
`ifdef DEMUX_BCAST_EN
    pending_nxt = pending;
`endif

    case (state)
      IDLE: state_nxt = IDLE;
      UNI: begin
        if (uni_drain) state_nxt = IDLE;
      end
`ifdef DEMUX_BCAST_EN
      BCAST: begin
        pending_nxt = pending_left;
        if (pending_left == ONEHOT_NONE) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase

    // A new transfer overrides the drain decision above: full throughput.
    if (in_fire) begin
      data_nxt = in_data;
      sel_nxt  = in_sel;
      if (bcast_req) begin
        state_nxt = BCAST;
`ifdef DEMUX_BCAST_EN
        pending_nxt = ONEHOT_ALL;
`endif
      end else begin
        state_nxt = UNI;
`ifdef DEMUX_BCAST_EN
        pending_nxt = ONEHOT_NONE;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel_q  <= '0;
      data_q <= '0;
`ifdef DEMUX_BCAST_EN
      pending <= ONEHOT_NONE;
`endif
    end else begin
      state  <= state_nxt;
      sel_q  <= sel_nxt;
      data_q <= data_nxt;
`ifdef DEMUX_BCAST_EN
      pending <= pending_nxt;
`endif
    end
  end

  assign dbg.state   = state;
  assign dbg.pending = pending_view;
  assign dbg.sel     = sel_q;

endmodule

// File: tb/tb_demux8_stream.sv
// Self-checking bench for demux8_stream: directed vector table, then randomized
// traffic compared against a held-word/owed-channels reference model.
module tb_demux8_stream;
  import demux8_pkg::*;

  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [2:0]       in_sel;
  logic             in_bcast;
  logic [W-1:0]     out_data;
  logic [7:0]       out_valid;
  logic [7:0]       out_ready;
  dbg_t             dbg;

  int checks = 0;
  int errors = 0;

  demux8_stream #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
`ifdef DEMUX_BCAST_EN
    .in_bcast  (in_bcast),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dbg       (dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // One held word plus the set of channels that are still owed it.
  logic         m_held;
  logic [7:0]   m_mask;
  logic [W-1:0] m_data;
  logic         m_bword;

  // ---------------- scoreboard ----------------
  logic [10:0]  exp_q[$];   // {channel, data} of unicast words awaiting delivery

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, sample before the edge, advance model at the edge.
  task automatic step(input logic r, input logic v, input logic b, input logic [2:0] s,
                      input logic [W-1:0] d, input logic [7:0] ordy,
                      output logic [7:0] s_ov, output logic [W-1:0] s_od, output logic s_ir);
    logic [7:0]  m_ov;
    logic        m_ir;
    logic [7:0]  delivered;
    logic [2:0]  ch;
    logic [10:0] exp_word;
    logic [7:0]  rem;
    rst_n = r; in_valid = v; in_bcast = b; in_sel = s; in_data = d; out_ready = ordy;
    #1;
    m_ov = m_held ? m_mask : 8'h00;
    m_ir = r && (!m_held || ((m_mask & ~ordy) == 8'h00));
    check("out_valid", {24'h0, out_valid}, {24'h0, m_ov});
    check("out_data",  {24'h0, out_data},  {24'h0, m_data});
    check("in_ready",  {31'h0, in_ready},  {31'h0, m_ir});
    s_ov = out_valid; s_od = out_data; s_ir = in_ready;

    delivered = out_valid & ordy;
    if (r && delivered != 8'h00 && !m_bword) begin
      ch = 3'd0;
      for (int i = 0; i < 8; i++) if (delivered[i]) ch = 3'(i);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_delivery: unexpected word %0h on ch %0d, nothing expected", out_data, ch);
      end else begin
        exp_word = exp_q.pop_front();
        check("sb_delivery", {21'h0, ch, out_data}, {21'h0, exp_word});
      end
    end

    @(posedge clk);
    if (!r) begin
      m_held = 1'b0; m_mask = 8'h00; m_data = '0; m_bword = 1'b0;
      exp_q.delete();
    end else if (v && m_ir) begin
      m_held = 1'b1; m_data = d; m_bword = b;
      m_mask = b ? 8'hFF : (8'h01 << s);
      if (!b) exp_q.push_back({s, d});
    end else begin
      rem = m_held ? (m_mask & ~ordy) : 8'h00;
      m_mask = rem;
      m_held = (rem != 8'h00);
    end
    @(negedge clk);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic         r, v, b;
    logic [2:0]   s;
    logic [W-1:0] d;
    logic [7:0]   ordy;
    logic [7:0]   e_ov;
    logic [W-1:0] e_od;
    logic         e_ir;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic b, input logic [2:0] s,
                     input logic [W-1:0] d, input logic [7:0] ordy,
                     input logic [7:0] e_ov, input logic [W-1:0] e_od, input logic e_ir);
    vec_t t;
    t.r = r; t.v = v; t.b = b; t.s = s; t.d = d; t.ordy = ordy;
    t.e_ov = e_ov; t.e_od = e_od; t.e_ir = e_ir;
    vecs.push_back(t);
  endtask

  initial begin
    logic [7:0]   ov;
    logic [W-1:0] od;
    logic         ir;
    logic         cr, cv, cb;
    logic [2:0]   cs;
    logic [W-1:0] cd;
    logic [7:0]   co;
    logic         hold;

    m_held = 1'b0; m_mask = 8'h00; m_data = '0; m_bword = 1'b0;
    rst_n = 1'b0; in_valid = 1'b1; in_bcast = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);

    // reset held with in_valid high
    add(0, 1, 0, 3'd0, 8'h77, 8'hFF, 8'h00, 8'h00, 0);
    add(0, 1, 0, 3'd0, 8'h77, 8'hFF, 8'h00, 8'h00, 0);
    // sweep, back-to-back
    add(1, 1, 0, 3'd0, 8'h01, 8'hFF, 8'h00, 8'h00, 1);
    for (int i = 1; i < 8; i++)
      add(1, 1, 0, 3'(i), 8'h01 << i, 8'hFF, 8'h01 << (i - 1), 8'h01 << (i - 1), 1);
    // backpressure on ch4 while the next word waits upstream
    add(1, 1, 0, 3'd4, 8'hA5, 8'hFF, 8'h80, 8'h80, 1);
    for (int i = 0; i < 3; i++)
      add(1, 1, 0, 3'd2, 8'h3C, 8'hEF, 8'h10, 8'hA5, 0);
    add(1, 1, 0, 3'd2, 8'h3C, 8'h10, 8'h10, 8'hA5, 1);
    // simultaneous drain and accept
    add(1, 1, 0, 3'd7, 8'hC3, 8'h04, 8'h04, 8'h3C, 1);
    add(1, 0, 0, 3'd0, 8'h00, 8'h00, 8'h80, 8'hC3, 0);
    add(1, 0, 0, 3'd0, 8'h00, 8'h7F, 8'h80, 8'hC3, 0);
    add(1, 0, 0, 3'd0, 8'h00, 8'h80, 8'h80, 8'hC3, 1);
    // reset while holding on ch5
    add(1, 1, 0, 3'd5, 8'h96, 8'h00, 8'h00, 8'hC3, 1);
    add(1, 0, 0, 3'd0, 8'h00, 8'h00, 8'h20, 8'h96, 0);
    add(0, 0, 0, 3'd0, 8'h00, 8'h00, 8'h20, 8'h96, 0);
    add(1, 0, 0, 3'd0, 8'h00, 8'hFF, 8'h00, 8'h00, 1);
    add(1, 0, 0, 3'd0, 8'h00, 8'hFF, 8'h00, 8'h00, 1);
`ifdef DEMUX_BCAST_EN
    add(1, 1, 1, 3'd3, 8'h5A, 8'h00, 8'h00, 8'h00, 1);
    add(1, 0, 0, 3'd0, 8'h00, 8'h0F, 8'hFF, 8'h5A, 0);
    add(1, 0, 0, 3'd0, 8'h00, 8'hF0, 8'hF0, 8'h5A, 1);
    add(1, 0, 0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h5A, 1);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].v, vecs[i].b, vecs[i].s, vecs[i].d, vecs[i].ordy, ov, od, ir);
      check($sformatf("vec%0d_out_valid", i), {24'h0, ov}, {24'h0, vecs[i].e_ov});
      check($sformatf("vec%0d_out_data", i),  {24'h0, od}, {24'h0, vecs[i].e_od});
      check($sformatf("vec%0d_in_ready", i),  {31'h0, ir}, {31'h0, vecs[i].e_ir});
    end

    // randomized traffic; upstream holds its word while stalled
    hold = 1'b0;
    cv = 1'b0; cb = 1'b0; cs = '0; cd = '0;
    for (int n = 0; n < 600; n++) begin
      cr = ($urandom_range(0, 99) != 0);
      if (!hold) begin
        cv = ($urandom_range(0, 3) != 0);
        cs = 3'($urandom_range(0, 7));
        cd = W'($urandom);
`ifdef DEMUX_BCAST_EN
        cb = ($urandom_range(0, 4) == 0);
`else
        cb = 1'b0;
`endif
      end
      case ($urandom_range(0, 2))
        0:       co = 8'hFF;
        1:       co = 8'($urandom);
        default: co = 8'h00;
      endcase
      step(cr, cv, cb, cs, cd, co, ov, od, ir);
      hold = cr && cv && !ir;
    end

    for (int n = 0; n < 12; n++)
      step(1, 0, 0, 3'd0, 8'h00, 8'hFF, ov, od, ir);
    check("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
